// File: rtl/scan_chain_controller.sv
// Scan chain initiator: serially loads a pattern word, pulses capture, unloads the response word.
// Optional MISR signature over responses when SCAN_CTRL_MISR_EN is defined.
module scan_chain_controller #(
  parameter int CHAIN_LEN = 8,
  parameter int CAPTURE_CYCLES = 1,
  parameter logic [CHAIN_LEN-1:0] MISR_POLY = 'h1D
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [CHAIN_LEN-1:0] pat_data,
  input  logic                 pat_valid,
  output logic                 pat_ready,
  output logic [CHAIN_LEN-1:0] rsp_data,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 scan_en,
  output logic                 scan_in,
  input  logic                 scan_out,
  output logic                 busy,
  input  logic                 sig_clr,
  output logic [CHAIN_LEN-1:0] sig
);

  localparam int BW = $clog2(CHAIN_LEN + 1);
  localparam int CW = $clog2(CAPTURE_CYCLES + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(CHAIN_LEN - 1);
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);
  localparam logic [CW-1:0] CAP_LAST = CW'(CAPTURE_CYCLES - 1);
  localparam logic [CW-1:0] CAP_ONE  = CW'(1);

  typedef enum logic [2:0] {IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT, RESP} state_t;

  state_t               state, state_nx;
  logic [BW-1:0]        bit_cnt, bit_cnt_nx;
  logic [CW-1:0]        cap_cnt, cap_cnt_nx;
  logic [CHAIN_LEN-1:0] sh, sh_nx;
  logic [CHAIN_LEN-1:0] rsp_q, rsp_nx;
  logic                 scan_en_q, scan_en_nx;
  logic                 scan_in_q, scan_in_nx;
  logic                 rsp_load;

  // sh doubles as the outgoing pattern register and the incoming response accumulator;
  // scan_en/scan_in are computed one cycle ahead so the pins come straight from flops.
  always_comb begin
    state_nx   = state;
    bit_cnt_nx = bit_cnt;
    cap_cnt_nx = cap_cnt;
    sh_nx      = sh;
    scan_en_nx = 1'b0;
    scan_in_nx = 1'b0;
    rsp_load   = 1'b0;
    rsp_nx     = {sh[CHAIN_LEN-2:0], scan_out};
    unique case (state)
      IDLE: begin
        if (pat_valid) begin
          state_nx   = SHIFT_IN;
          sh_nx      = {pat_data[CHAIN_LEN-2:0], 1'b0};
          scan_en_nx = 1'b1;
          scan_in_nx = pat_data[CHAIN_LEN-1];
          bit_cnt_nx = '0;
        end
      end
      SHIFT_IN: begin
        if (bit_cnt == BIT_LAST) begin
          state_nx   = CAPTURE;
          bit_cnt_nx = '0;
          cap_cnt_nx = '0;
        end else begin
          scan_en_nx = 1'b1;
          scan_in_nx = sh[CHAIN_LEN-1];
          sh_nx      = {sh[CHAIN_LEN-2:0], 1'b0};
          bit_cnt_nx = bit_cnt + BIT_ONE;
        end
      end
      CAPTURE: begin
        if (cap_cnt == CAP_LAST) begin
          state_nx   = SHIFT_OUT;
          scan_en_nx = 1'b1;
          cap_cnt_nx = '0;
        end else begin
          cap_cnt_nx = cap_cnt + CAP_ONE;
        end
      end
      SHIFT_OUT: begin
        sh_nx = {sh[CHAIN_LEN-2:0], scan_out};
        if (bit_cnt == BIT_LAST) begin
          state_nx   = RESP;
          bit_cnt_nx = '0;
          rsp_load   = 1'b1;
        end else begin
          scan_en_nx = 1'b1;
          bit_cnt_nx = bit_cnt + BIT_ONE;
        end
      end
      RESP: begin
        if (rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      cap_cnt   <= '0;
      sh        <= '0;
      rsp_q     <= '0;
      scan_en_q <= 1'b0;
      scan_in_q <= 1'b0;
    end else begin
      state     <= state_nx;
      bit_cnt   <= bit_cnt_nx;
      cap_cnt   <= cap_cnt_nx;
      sh        <= sh_nx;
      scan_en_q <= scan_en_nx;
      scan_in_q <= scan_in_nx;
      if (rsp_load) rsp_q <= rsp_nx;
    end
  end

  assign scan_en   = scan_en_q;
  assign scan_in   = scan_in_q;
  assign pat_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);
  assign rsp_data  = rsp_q;

`ifdef SCAN_CTRL_MISR_EN
  function automatic logic [CHAIN_LEN-1:0] misr_step(input logic [CHAIN_LEN-1:0] cur,
                                                     input logic [CHAIN_LEN-1:0] din);
    misr_step = {cur[CHAIN_LEN-2:0], 1'b0} ^ (cur[CHAIN_LEN-1] ? MISR_POLY : '0) ^ din;
  endfunction

  logic [CHAIN_LEN-1:0] sig_q;

  // One signature step per response, on the edge that enters RESP; clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        sig_q <= '0;
    else if (sig_clr)  sig_q <= '0;
    else if (rsp_load) sig_q <= misr_step(sig_q, rsp_nx);
  end

  assign sig = sig_q;
`else
  logic unused_misr;
  assign unused_misr = sig_clr | (|MISR_POLY);
  assign sig = '0;
`endif

`ifndef SYNTHESIS
  a_quiet_chain: assert property (@(posedge clk) disable iff (!rst_n)
    (state == IDLE || state == RESP) |-> !scan_en_q);
  a_rsp_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (state == RESP && !rsp_ready) |=> (state == RESP && $stable(rsp_q)));
`endif

endmodule

// File: tb/tb_scan_chain_controller.sv
// Directed bench for scan_chain_controller driving a behavioural 8-bit scan chain whose
// functional input is fixed at 0x3C; two DUTs cover one- and two-cycle capture windows.
`timescale 1ns/1ps
module tb_scan_chain_controller;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] pat_data1, rsp_data1, sig1, chain1;
  logic       pat_valid1, pat_ready1, rsp_valid1, rsp_ready1;
  logic       scan_en1, scan_in1, scan_out1, busy1, sig_clr1;

  logic [7:0] pat_data2, rsp_data2, sig2, chain2;
  logic       pat_valid2, pat_ready2, rsp_valid2, rsp_ready2;
  logic       scan_en2, scan_in2, scan_out2, busy2, sig_clr2;

  scan_chain_controller #(.CHAIN_LEN(8), .CAPTURE_CYCLES(1), .MISR_POLY(8'h1D)) dut1 (
    .clk(clk), .rst_n(rst_n), .pat_data(pat_data1), .pat_valid(pat_valid1),
    .pat_ready(pat_ready1), .rsp_data(rsp_data1), .rsp_valid(rsp_valid1),
    .rsp_ready(rsp_ready1), .scan_en(scan_en1), .scan_in(scan_in1),
    .scan_out(scan_out1), .busy(busy1), .sig_clr(sig_clr1), .sig(sig1));

  scan_chain_controller #(.CHAIN_LEN(8), .CAPTURE_CYCLES(2), .MISR_POLY(8'h1D)) dut2 (
    .clk(clk), .rst_n(rst_n), .pat_data(pat_data2), .pat_valid(pat_valid2),
    .pat_ready(pat_ready2), .rsp_data(rsp_data2), .rsp_valid(rsp_valid2),
    .rsp_ready(rsp_ready2), .scan_en(scan_en2), .scan_in(scan_in2),
    .scan_out(scan_out2), .busy(busy2), .sig_clr(sig_clr2), .sig(sig2));

  // Chain of scan cells: shift toward bit 7 when scan_en, otherwise capture data_in.
  assign scan_out1 = chain1[7];
  assign scan_out2 = chain2[7];
  always @(posedge clk) chain1 <= scan_en1 ? {chain1[6:0], scan_in1} : 8'h3C;
  always @(posedge clk) chain2 <= scan_en2 ? {chain2[6:0], scan_in2} : 8'h3C;

`ifdef SCAN_CTRL_MISR_EN
  localparam logic [7:0] SIG_ONE = 8'h3C;
  localparam logic [7:0] SIG_TWO = 8'h44;
`else
  localparam logic [7:0] SIG_ONE = 8'h00;
  localparam logic [7:0] SIG_TWO = 8'h00;
`endif

  typedef struct {
    logic [7:0] pat;
    int         hold;
    logic [7:0] exp_rsp;
  } vec_t;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full transaction on dut1 (one capture cycle) with per-cycle pin checks.
  task automatic run1(input logic [7:0] pat, input int hold, input bit keep,
                      input logic [7:0] nxt, input logic [7:0] exp_rsp, output int waitn);
    logic [7:0] p;
    pat_data1  = pat;
    pat_valid1 = 1'b1;
    waitn = 0;
    while (!pat_ready1 && waitn < 40) begin
      step();
      waitn++;
    end
    chk("accept_ready", 32'(pat_ready1), 1);
    step();
    if (keep) pat_data1 = nxt;
    else pat_valid1 = 1'b0;
    p = pat;
    for (int k = 0; k < 8; k++) begin
      chk("shin_en", 32'(scan_en1), 1);
      chk("shin_bit", 32'(scan_in1), 32'(p[7]));
      chk("shin_busy", 32'(busy1), 1);
      p = p << 1;
      step();
    end
    chk("cap_en", 32'(scan_en1), 0);
    chk("cap_in", 32'(scan_in1), 0);
    chk("chain_loaded", 32'(chain1), 32'(pat));
    step();
    for (int k = 0; k < 8; k++) begin
      chk("shout_en", 32'(scan_en1), 1);
      chk("shout_in", 32'(scan_in1), 0);
      chk("shout_vld", 32'(rsp_valid1), 0);
      step();
    end
    chk("rsp_valid", 32'(rsp_valid1), 1);
    chk("rsp_data", 32'(rsp_data1), 32'(exp_rsp));
    chk("rsp_pat_ready", 32'(pat_ready1), 0);
    chk("rsp_scan_en", 32'(scan_en1), 0);
    for (int h = 0; h < hold; h++) begin
      step();
      chk("hold_valid", 32'(rsp_valid1), 1);
      chk("hold_data", 32'(rsp_data1), 32'(exp_rsp));
      chk("hold_pat_ready", 32'(pat_ready1), 0);
    end
    rsp_ready1 = 1'b1;
    step();
    rsp_ready1 = 1'b0;
    chk("post_valid", 32'(rsp_valid1), 0);
    chk("post_pat_ready", 32'(pat_ready1), 1);
    chk("post_busy", 32'(busy1), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[5];
    int   w;
    vecs[0] = '{pat: 8'hA5, hold: 0, exp_rsp: 8'h3C};
    vecs[1] = '{pat: 8'h3C, hold: 5, exp_rsp: 8'h3C};
    vecs[2] = '{pat: 8'h00, hold: 1, exp_rsp: 8'h3C};
    vecs[3] = '{pat: 8'h5A, hold: 2, exp_rsp: 8'h3C};
    vecs[4] = '{pat: 8'h81, hold: 0, exp_rsp: 8'h3C};

    pat_data1 = '0; pat_valid1 = 1'b0; rsp_ready1 = 1'b0; sig_clr1 = 1'b0;
    pat_data2 = '0; pat_valid2 = 1'b0; rsp_ready2 = 1'b0; sig_clr2 = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_scan_en", 32'(scan_en1), 0);
    chk("rst_scan_in", 32'(scan_in1), 0);
    chk("rst_pat_ready", 32'(pat_ready1), 1);
    chk("rst_rsp_valid", 32'(rsp_valid1), 0);
    chk("rst_rsp_data", 32'(rsp_data1), 0);
    chk("rst_busy", 32'(busy1), 0);
    chk("rst_sig", 32'(sig1), 0);
    rst_n = 1'b1;
    step();

    // Two-cycle capture window on dut2.
    pat_data2 = 8'hFF;
    pat_valid2 = 1'b1;
    chk("d2_ready", 32'(pat_ready2), 1);
    step();
    pat_valid2 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk("d2_shin_en", 32'(scan_en2), 1);
      chk("d2_shin_bit", 32'(scan_in2), 1);
      step();
    end
    chk("d2_cap1_en", 32'(scan_en2), 0);
    chk("d2_chain_loaded", 32'(chain2), 32'hFF);
    step();
    chk("d2_cap2_en", 32'(scan_en2), 0);
    chk("d2_cap2_in", 32'(scan_in2), 0);
    step();
    for (int k = 0; k < 8; k++) begin
      chk("d2_shout_en", 32'(scan_en2), 1);
      chk("d2_shout_vld", 32'(rsp_valid2), 0);
      step();
    end
    chk("d2_rsp_valid", 32'(rsp_valid2), 1);
    chk("d2_rsp_data", 32'(rsp_data2), 32'h3C);
    rsp_ready2 = 1'b1;
    step();
    rsp_ready2 = 1'b0;
    chk("d2_idle", 32'(busy2), 0);
    chk("d2_sig", 32'(sig2), 32'(SIG_ONE));

    for (int i = 0; i < 5; i++) begin
      run1(vecs[i].pat, vecs[i].hold, 1'b0, 8'h00, vecs[i].exp_rsp, w);
    end

    // Back-to-back with pat_valid held high throughout.
    run1(8'h00, 0, 1'b1, 8'hFF, 8'h3C, w);
    run1(8'hFF, 0, 1'b0, 8'h00, 8'h3C, w);
    chk("b2b_accept_wait", 32'(w), 0);

    // Reset in the fourth shift-in cycle.
    pat_data1 = 8'h33;
    pat_valid1 = 1'b1;
    step();
    pat_valid1 = 1'b0;
    step();
    step();
    step();
    chk("mid_shift_en", 32'(scan_en1), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_scan_en", 32'(scan_en1), 0);
    chk("mid_rst_scan_in", 32'(scan_in1), 0);
    chk("mid_rst_busy", 32'(busy1), 0);
    chk("mid_rst_rsp_valid", 32'(rsp_valid1), 0);
    chk("mid_rst_pat_ready", 32'(pat_ready1), 1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    run1(8'h5A, 0, 1'b0, 8'h00, 8'h3C, w);

    // Signature: clear, then two responses.
    sig_clr1 = 1'b1;
    step();
    sig_clr1 = 1'b0;
    chk("sig_clear", 32'(sig1), 0);
    run1(8'h11, 0, 1'b0, 8'h00, 8'h3C, w);
    chk("sig_first", 32'(sig1), 32'(SIG_ONE));
    run1(8'h22, 0, 1'b0, 8'h00, 8'h3C, w);
    chk("sig_second", 32'(sig1), 32'(SIG_TWO));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
